// File: rtl/full_adder_pkg.sv
// Shared constants for the registered ripple-carry adder: width limit and
// the values the output registers take while rst_n is low.
package full_adder_pkg;

    localparam int FA_MAX_WIDTH = 64;

    localparam logic [FA_MAX_WIDTH-1:0] FA_RST_SUM   = '0;
    localparam logic                    FA_RST_COUT  = 1'b0;
    localparam logic                    FA_RST_OVF   = 1'b0;
    localparam logic                    FA_RST_VALID = 1'b0;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder; chained co -> ci to build the ripple adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {Cout, S} = A + B + Cin, one cycle latency,
// signed overflow flag and a valid pulse per accepted operand set.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             out_valid
);

    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
        $fatal(1, "full_adder: WIDTH=%0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
    end

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;

    assign carry[0] = Cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        full_adder_cell u_cell (
            .a  (A[gi]),
            .b  (B[gi]),
            .ci (carry[gi]),
            .s  (sum_bits[gi]),
            .co (carry[gi+1])
        );
    end

    logic [WIDTH-1:0] sum_d,  sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d,  ovf_q;
    logic             valid_d, valid_q;

    // Results only move when in_valid is high, so X/Z on idle inputs never
    // reaches the held outputs.
    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d  = sum_bits;
            cout_d = carry[WIDTH];
            ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= FA_RST_SUM[WIDTH-1:0];
            cout_q  <= FA_RST_COUT;
            ovf_q   <= FA_RST_OVF;
            valid_q <= FA_RST_VALID;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign S         = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH = 1, 4 and 8 sharing one clock/reset.
module tb_full_adder;

    typedef struct {
        logic [63:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: exact (WIDTH+1)-bit sum; overflow when same-signed operands
    // give a result of the other sign.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b, input logic c);
        logic [64:0] sum;
        logic [63:0] mask;
        exp_t e;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        sum  = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, c};
        e.s  = sum[63:0] & mask;
        e.co = sum[w];
        e.ov = (a[w-1] == b[w-1]) && (sum[w-1] != a[w-1]);
        return e;
    endfunction

    // ---------------- DUT instances ----------------
    logic       iv1, a1, b1, c1, s1, co1, ov1, vo1;
    logic       iv4, c4, co4, ov4, vo4;
    logic [3:0] a4, b4, s4;
    logic       iv8, c8, co8, ov8, vo8;
    logic [7:0] a8, b8, s8;

    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .A(a1), .B(b1), .Cin(c1),
        .S(s1), .Cout(co1), .Ovf(ov1), .out_valid(vo1)
    );
    full_adder #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .A(a4), .B(b4), .Cin(c4),
        .S(s4), .Cout(co4), .Ovf(ov4), .out_valid(vo4)
    );
    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .A(a8), .B(b8), .Cin(c8),
        .S(s8), .Cout(co8), .Ovf(ov8), .out_valid(vo8)
    );

    exp_t q1[$];
    exp_t q4[$];
    exp_t q8[$];

    // Inputs change on the falling edge; expected results are queued then and
    // must show up just after the following rising edge.
    task automatic drive1(input logic a, input logic b, input logic c, input logic v, input exp_t e);
        @(negedge clk);
        iv1 = v; a1 = a; b1 = b; c1 = c;
        if (v) q1.push_back(e);
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic v, input exp_t e);
        @(negedge clk);
        iv4 = v; a4 = a; b4 = b; c4 = c;
        if (v) q4.push_back(e);
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v, input exp_t e);
        @(negedge clk);
        iv8 = v; a8 = a; b8 = b; c8 = c;
        if (v) q8.push_back(e);
    endtask

    // ---------------- scoreboards ----------------
    always @(posedge clk) begin
        exp_t e;
        #1;
        check("w1_valid", {63'd0, vo1}, {63'd0, q1.size() != 0});
        if (q1.size() != 0) begin
            e = q1.pop_front();
            check("w1_s",   {63'd0, s1},  e.s);
            check("w1_co",  {63'd0, co1}, {63'd0, e.co});
            check("w1_ovf", {63'd0, ov1}, {63'd0, e.ov});
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        check("w4_valid", {63'd0, vo4}, {63'd0, q4.size() != 0});
        if (q4.size() != 0) begin
            e = q4.pop_front();
            check("w4_s",   {60'd0, s4},  e.s);
            check("w4_co",  {63'd0, co4}, {63'd0, e.co});
            check("w4_ovf", {63'd0, ov4}, {63'd0, e.ov});
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        check("w8_valid", {63'd0, vo8}, {63'd0, q8.size() != 0});
        if (q8.size() != 0) begin
            e = q8.pop_front();
            check("w8_s",   {56'd0, s8},  e.s);
            check("w8_co",  {63'd0, co8}, {63'd0, e.co});
            check("w8_ovf", {63'd0, ov8}, {63'd0, e.ov});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] tt [8];
        exp_t e;
        exp_t none;
        logic [7:0] ra, rb;
        logic       rc;

        tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        none = '{s: 64'd0, co: 1'b0, ov: 1'b0};
        iv1 = 0; a1 = 0; b1 = 0; c1 = 0;
        iv4 = 0; a4 = 0; b4 = 0; c4 = 0;
        iv8 = 0; a8 = 0; b8 = 0; c8 = 0;

        repeat (2) @(negedge clk);
        check("rst_s8",    {56'd0, s8},  64'd0);
        check("rst_co8",   {63'd0, co8}, 64'd0);
        check("rst_valid", {63'd0, vo8}, 64'd0);
        rst_n = 1'b1;

        // 1-bit truth table, {Cout,S} from the textbook table.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc  = i[2:0];
            e    = model(1, {63'd0, abc[2]}, {63'd0, abc[1]}, abc[0]);
            e.s  = {63'd0, tt[i][0]};
            e.co = tt[i][1];
            drive1(abc[2], abc[1], abc[0], 1'b1, e);
        end
        drive1(1'b0, 1'b0, 1'b0, 1'b0, none);

        // Asynchronous reset mid-cycle after 1+1+1 is registered.
        drive1(1'b1, 1'b1, 1'b1, 1'b1, model(1, 64'd1, 64'd1, 1'b1));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        q1.delete(); q4.delete(); q8.delete();
        #1;
        check("async_rst_s",     {63'd0, s1},  64'd0);
        check("async_rst_co",    {63'd0, co1}, 64'd0);
        check("async_rst_ovf",   {63'd0, ov1}, 64'd0);
        check("async_rst_valid", {63'd0, vo1}, 64'd0);
        @(negedge clk);
        iv1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Hold: idle inputs change but registered result must stay.
        drive1(1'b1, 1'b0, 1'b0, 1'b1, model(1, 64'd1, 64'd0, 1'b0));
        drive1(1'b1, 1'b1, 1'b1, 1'b0, none);
        @(posedge clk);
        #2;
        check("hold_s",     {63'd0, s1},  64'd1);
        check("hold_co",    {63'd0, co1}, 64'd0);
        check("hold_valid", {63'd0, vo1}, 64'd0);

        // WIDTH=8 directed carry ripple and signed overflow.
        drive8(8'hFF, 8'h00, 1'b1, 1'b1, model(8, 64'hFF, 64'h00, 1'b1));
        @(posedge clk);
        #2;
        check("rip_s",   {56'd0, s8},  64'h00);
        check("rip_co",  {63'd0, co8}, 64'd1);
        check("rip_ovf", {63'd0, ov8}, 64'd0);
        drive8(8'h7F, 8'h01, 1'b0, 1'b1, model(8, 64'h7F, 64'h01, 1'b0));
        @(posedge clk);
        #2;
        check("ovf_s",   {56'd0, s8},  64'h80);
        check("ovf_co",  {63'd0, co8}, 64'd0);
        check("ovf_ovf", {63'd0, ov8}, 64'd1);

        // WIDTH=8 back-to-back random stream.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            drive8(ra, rb, rc, 1'b1, model(8, {56'd0, ra}, {56'd0, rb}, rc));
        end
        drive8(8'h00, 8'h00, 1'b0, 1'b0, none);

        // WIDTH=4 reset released while in_valid is already high.
        @(negedge clk);
        rst_n = 1'b0;
        q1.delete(); q4.delete(); q8.delete();
        iv4 = 1'b1; a4 = 4'd3; b4 = 4'd4; c4 = 1'b0;
        @(negedge clk);
        check("rel_held_valid", {63'd0, vo4}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q4.push_back(model(4, 64'd3, 64'd4, 1'b0));
        @(posedge clk);
        #2;
        check("rel_s",     {60'd0, s4},  64'd7);
        check("rel_co",    {63'd0, co4}, 64'd0);
        check("rel_valid", {63'd0, vo4}, 64'd1);
        @(negedge clk);
        iv4 = 1'b0;

        repeat (3) @(negedge clk);
        if (q1.size() + q4.size() + q8.size() != 0)
            check("sb_drained", 64'(q1.size() + q4.size() + q8.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
